// File: rtl/result_logger_pkg.sv
// result_logger_pkg: shared FSM state encoding and default debounce length for the result logger.
package result_logger_pkg;

    typedef enum logic [1:0] {
        S_CAPTURE = 2'b00,
        S_FULL    = 2'b01,
        S_REVIEW  = 2'b10
    } state_t;

    localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/result_logger_key_debounce.sv
// key_debounce: synchronizes a raw active-low key, debounces it and emits a one-cycle press pulse.
module key_debounce
    import result_logger_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // The synchronized level must disagree with the accepted level for CYCLES consecutive samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                press <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_logger.sv
// result_logger: captures result/reference word pairs, counts mismatches and lets keys step through the log.
module result_logger
    import result_logger_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       capture,
    input  logic [2*DATA_WIDTH-1:0]    data_in,
    input  logic [2*DATA_WIDTH-1:0]    expected,
    input  logic                       review_n,
    input  logic                       next_n,
    output logic [2*DATA_WIDTH-1:0]    rd_data,
    output logic [$clog2(DEPTH)-1:0]   rd_index,
    output logic                       rd_mismatch,
    output logic [$clog2(DEPTH):0]     err_count,
    output logic                       full,
    output logic [2:0]                 code
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = 2 * DATA_WIDTH;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    state_t          state;
    logic [WW-1:0]   mem [DEPTH];
    logic [DEPTH-1:0] flag;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     entries;
    logic            wr_en;
    logic            miss;
    logic            review_press;
    logic            next_press;

    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_review (
        .clk(clk), .reset_n(reset_n), .key_n(review_n), .press(review_press)
    );

    key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .reset_n(reset_n), .key_n(next_n), .press(next_press)
    );

    // wr_ptr wraps to 0 exactly when full sets, so {full, wr_ptr} is the stored entry count.
    assign entries  = {full, wr_ptr};
    assign wr_en    = capture && state == S_CAPTURE;
    assign miss     = data_in != expected;
    assign rd_index = rd_ptr;
    assign code     = {state, err_count != '0};

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_CAPTURE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_count   <= '0;
            full        <= 1'b0;
            flag        <= '0;
            rd_data     <= '0;
            rd_mismatch <= 1'b0;
        end else begin
            rd_data     <= entries != '0 ? mem[rd_ptr] : '0;
            rd_mismatch <= entries != '0 && flag[rd_ptr];
            if (wr_en) begin
                flag[wr_ptr] <= miss;
                wr_ptr       <= wr_ptr + 1'b1;
                if (miss && err_count != DEPTH_W) err_count <= err_count + 1'b1;
                if (wr_ptr == AW'(DEPTH - 1)) begin
                    full  <= 1'b1;
                    state <= S_FULL;
                end
            end
            // A coincident review press overrides the capture-side state update after the write.
            if (review_press) begin
                if (state == S_REVIEW) begin
                    state <= full ? S_FULL : S_CAPTURE;
                end else begin
                    state  <= S_REVIEW;
                    rd_ptr <= '0;
                end
            end else if (next_press && state == S_REVIEW && entries != '0) begin
                rd_ptr <= {1'b0, rd_ptr} == entries - 1'b1 ? '0 : rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_logger.sv
// tb_result_logger: randomized self-checking bench comparing result_logger against a queue-based log model.
module tb_result_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] expected = '0;
    logic        review_n = 1'b1;
    logic        next_n = 1'b1;
    logic [15:0] rd_data;
    logic [2:0]  rd_index;
    logic        rd_mismatch;
    logic [3:0]  err_count;
    logic        full;
    logic [2:0]  code;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_data[$];
    bit          m_flag[$];
    int          m_state = 0;
    int          m_rd = 0;
    int          m_err = 0;

    result_logger #(.DATA_WIDTH(8), .DEPTH(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .capture(capture), .data_in(data_in),
        .expected(expected), .review_n(review_n), .next_n(next_n), .rd_data(rd_data),
        .rd_index(rd_index), .rd_mismatch(rd_mismatch), .err_count(err_count),
        .full(full), .code(code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        step();
        chk({tag, ".state"}, 32'(code[2:1]), 32'(m_state));
        chk({tag, ".code0"}, 32'(code[0]), 32'(m_err != 0));
        chk({tag, ".err"}, 32'(err_count), 32'(m_err));
        chk({tag, ".full"}, 32'(full), 32'(m_data.size() == 8));
        chk({tag, ".idx"}, 32'(rd_index), 32'(m_rd));
        chk({tag, ".data"}, 32'(rd_data), m_data.size() == 0 ? 32'h0 : 32'(m_data[m_rd]));
        chk({tag, ".miss"}, 32'(rd_mismatch), m_data.size() == 0 ? 32'h0 : 32'(m_flag[m_rd]));
    endtask

    function automatic void model_capture(input logic [15:0] d, input logic [15:0] e);
        if (m_state != 0) return;
        m_data.push_back(d);
        m_flag.push_back(d != e);
        if (d != e && m_err < 8) m_err++;
        if (m_data.size() == 8) m_state = 1;
    endfunction

    function automatic void model_review();
        if (m_state == 2) begin
            m_state = m_data.size() == 8 ? 1 : 0;
        end else begin
            m_state = 2;
            m_rd = 0;
        end
    endfunction

    task automatic do_capture(input logic [15:0] d, input logic [15:0] e);
        capture = 1'b1;
        data_in = d;
        expected = e;
        step();
        capture = 1'b0;
        model_capture(d, e);
    endtask

    task automatic press(input bit is_next);
        if (is_next) next_n = 1'b0; else review_n = 1'b0;
        repeat (8) step();
        next_n = 1'b1;
        review_n = 1'b1;
        repeat (8) step();
        if (!is_next) model_review();
        else if (m_state == 2 && m_data.size() > 0) m_rd = (m_rd + 1) % m_data.size();
    endtask

    task automatic bounce(input bit is_next);
        repeat (3) begin
            if (is_next) next_n = 1'b0; else review_n = 1'b0;
            repeat (2) step();
            next_n = 1'b1;
            review_n = 1'b1;
            repeat (2) step();
        end
        repeat (8) step();
    endtask

    task automatic do_reset(input string tag);
        capture = 1'b0;
        review_n = 1'b1;
        next_n = 1'b1;
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_code"}, 32'(code), 32'h0);
        chk({tag, ".rst_err"}, 32'(err_count), 32'h0);
        chk({tag, ".rst_full"}, 32'(full), 32'h0);
        chk({tag, ".rst_idx"}, 32'(rd_index), 32'h0);
        chk({tag, ".rst_data"}, 32'(rd_data), 32'h0);
        chk({tag, ".rst_miss"}, 32'(rd_mismatch), 32'h0);
        step();
        reset_n = 1'b1;
        m_data.delete();
        m_flag.delete();
        m_state = 0;
        m_rd = 0;
        m_err = 0;
    endtask

    initial begin
        logic [15:0] d;
        do_reset("init");
        check_all("reset");

        do_capture(16'h0010, 16'h0010);
        do_capture(16'h0021, 16'h0020);
        do_capture(16'h0032, 16'h0032);
        check_all("three");
        chk("three.code", 32'(code), 32'h1);

        press(1'b0);
        check_all("rev0");
        chk("rev0.word", 32'(rd_data), 32'h0010);
        press(1'b1);
        check_all("rev1");
        chk("rev1.word", 32'(rd_data), 32'h0021);
        chk("rev1.miss", 32'(rd_mismatch), 32'h1);
        press(1'b1);
        check_all("rev2");
        chk("rev2.word", 32'(rd_data), 32'h0032);
        press(1'b1);
        check_all("rev_wrap");
        chk("rev_wrap.idx", 32'(rd_index), 32'h0);

        bounce(1'b1);
        check_all("bounce");
        press(1'b1);
        check_all("after_bounce");
        chk("after_bounce.idx", 32'(rd_index), 32'h1);
        press(1'b0);
        check_all("back_capture");

        do_reset("fill");
        for (int i = 0; i < 8; i++) do_capture(16'(i * 16'h0101 + 1), 16'(i * 16'h0101 + 1));
        do_capture(16'hFFFF, 16'h0000);
        check_all("full");
        chk("full.code21", 32'(code[2:1]), 32'h1);
        press(1'b0);
        check_all("full_rev");
        chk("full_rev.word", 32'(rd_data), 32'h0001);
        press(1'b0);
        check_all("full_back");

        do_reset("coinc");
        do_capture(16'h1234, 16'h1234);
        review_n = 1'b0;
        repeat (6) step();
        capture = 1'b1;
        data_in = 16'hBEEF;
        expected = 16'h0000;
        step();
        capture = 1'b0;
        model_capture(16'hBEEF, 16'h0000);
        model_review();
        repeat (5) step();
        review_n = 1'b1;
        repeat (8) step();
        check_all("coinc");
        chk("coinc.entries_err", 32'(err_count), 32'h1);

        do_reset("mid");
        do_capture(16'h0001, 16'h0002);
        do_capture(16'h0003, 16'h0004);
        press(1'b0);
        check_all("mid_rev");
        do_reset("mid");
        check_all("mid_after");

        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            d = 16'($urandom_range(0, 16'hFFFF));
            if (op < 5) do_capture(d, $urandom_range(0, 1) ? d : d ^ 16'($urandom_range(1, 16'hFFFF)));
            else if (op < 7) press(1'b1);
            else if (op == 7) press(1'b0);
            else if (op == 8) bounce($urandom_range(0, 1) == 1);
            else if ($urandom_range(0, 3) == 0) do_reset("rand");
            check_all($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_logger.md
RESULT_LOGGER -- requirements
Module: result_logger

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning operand width; captured words are 2*DATA_WIDTH bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning capture buffer entries; must be a power of two, at least 2.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning cycles a key level must hold stable before it is accepted.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 capture  input  1  active-high, one-cycle strobe; records data_in and expected.
REQ-007 data_in  input  2*DATA_WIDTH  systolic cell result word.
REQ-008 expected  input  2*DATA_WIDTH  reference result for the same vector.
REQ-009 review_n  input  1  raw active-low push key; toggles capture/review mode.
REQ-010 next_n  input  1  raw active-low push key; advances the review index.
REQ-011 rd_data  output  2*DATA_WIDTH  stored word at rd_index, registered.
REQ-012 rd_index  output  $clog2(DEPTH)  current review index.
REQ-013 rd_mismatch  output  1  stored mismatch flag at rd_index, registered.
REQ-014 err_count  output  $clog2(DEPTH)+1  number of mismatching captures, saturating at DEPTH.
REQ-015 full  output  1  high when DEPTH entries are stored.
REQ-016 code  output  3  LED status: code[2:1] = state encoding, code[0] = (err_count != 0).

Function
REQ-017 FSM states SHALL be S_CAPTURE=2'b00, S_FULL=2'b01, S_REVIEW=2'b10.
REQ-018 Keys SHALL pass through a 2-flop synchronizer and a debouncer; only a debounced high-to-low transition SHALL count as a press (one event per press).
REQ-019 In S_CAPTURE, capture=1 SHALL write data_in to mem[wr_ptr] and (data_in != expected) to flag[wr_ptr].
REQ-020 On that capture, wr_ptr SHALL increment, and err_count SHALL increment on mismatch, in the same cycle.
REQ-021 When the write fills entry DEPTH-1, the next state SHALL be S_FULL and full SHALL assert on the following cycle.
REQ-022 In S_FULL and S_REVIEW, capture SHALL be ignored; no memory, pointer or counter changes.
REQ-023 A review press in S_CAPTURE or S_FULL SHALL enter S_REVIEW with rd_ptr=0.
REQ-024 A review press in S_REVIEW SHALL return to S_FULL if full, else S_CAPTURE; rd_ptr is retained.
REQ-025 A next press in S_REVIEW SHALL advance rd_ptr, wrapping to 0 after entry count-1.
REQ-026 A next press outside S_REVIEW, or with zero stored entries, SHALL be ignored.
REQ-027 rd_data and rd_mismatch SHALL update exactly one cycle after rd_ptr changes; with zero entries they SHALL read 0.
REQ-028 If capture and a review press occur in the same S_CAPTURE cycle, the write SHALL complete first, and the state SHALL go to S_REVIEW in that same edge.
REQ-029 rd_index SHALL equal rd_ptr combinationally.

Reset
REQ-030 reset_n low SHALL asynchronously clear state to S_CAPTURE, wr_ptr, rd_ptr, err_count, full, rd_data, rd_mismatch, all mismatch flags, and debouncer state to released.
REQ-031 Memory data contents need not clear; a reset mid-review or mid-press SHALL discard the pending press.

Structure
REQ-032 result_logger_pkg SHALL hold the state enum typedef and the default DEBOUNCE_CYCLES constant.
REQ-033 One sub-module key_debounce (sync, counter, falling-edge pulse) SHALL be instantiated twice; memory SHALL be an inferred register array.

Verification (DEBOUNCE_CYCLES=4, DEPTH=8, DATA_WIDTH=8)
REQ-034 Scenario: capture 3 words 0x0010/0x0010, 0x0021/0x0020, 0x0032/0x0032 -> err_count=1, full=0, code=3'b001.
REQ-035 Scenario: 8 captures then a 9th with 0xFFFF -> full=1, code[2:1]=01, and a later review of entry 0 does not show 0xFFFF.
REQ-036 Scenario: after REQ-034 data, press review then next twice -> rd_data is 0x0010, 0x0021, 0x0032 on successive indices, rd_mismatch=0,1,0, and a third next returns rd_index=0.
REQ-037 Scenario: next_n bounces for 2-cycle pulses -> no index change; held for 4+ cycles -> exactly one advance.
REQ-038 Scenario: capture coincident with a review press -> entry is written, state=S_REVIEW, rd_data equals entry 0 one cycle later.
REQ-039 Scenario: assert reset_n low in S_REVIEW with err_count=2 -> all outputs 0 immediately, state S_CAPTURE.
